// File: rtl/cluster_lockstep_ctrl_periph.sv
// Lockstep control/status target on the cluster peripheral interconnect.
// Counts core-pair mismatch events, captures the first one, and raises fault IRQ/halt at threshold.
module cluster_lockstep_ctrl_periph #(
  parameter int NB_CORES          = 8,
  parameter int ID_WIDTH          = 5,
  parameter int CNT_WIDTH         = 16,
  parameter int DEFAULT_THRESHOLD = 1,
  localparam int CORE_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                speriph_req_i,
  input  logic [31:0]         speriph_add_i,
  input  logic                speriph_wen_i,
  input  logic [31:0]         speriph_wdata_i,
  input  logic [3:0]          speriph_be_i,
  input  logic [ID_WIDTH-1:0] speriph_id_i,
  output logic                speriph_gnt_o,
  output logic                speriph_r_valid_o,
  output logic [31:0]         speriph_r_rdata_o,
  output logic                speriph_r_opc_o,
  output logic [ID_WIDTH-1:0] speriph_r_id_o,
  input  logic                mismatch_i,
  input  logic [CORE_W-1:0]   mismatch_core_i,
  input  logic [31:0]         mismatch_pc_i,
  output logic                lockstep_en_o,
  output logic                fault_irq_o,
  output logic                core_halt_o
);

  // Handshake: the target is always ready, so gnt mirrors req; each granted request
  // yields exactly one r_valid pulse on the following cycle, in issue order.

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  localparam logic [3:0] IDX_CTRL       = 4'd0;
  localparam logic [3:0] IDX_STATUS     = 4'd1;
  localparam logic [3:0] IDX_CNT        = 4'd2;
  localparam logic [3:0] IDX_FIRST_PC   = 4'd3;
  localparam logic [3:0] IDX_FIRST_CORE = 4'd4;
  localparam logic [3:0] IDX_THRESHOLD  = 4'd5;

  state_e               state_q, state_d, state_eff;
  logic [2:0]           ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] thr_q, thr_d, thr_eff;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
  logic [31:0]          first_pc_q, first_pc_d;
  logic [CORE_W-1:0]    first_core_q, first_core_d;

  logic [3:0]  reg_idx;
  logic        wr_en, rd_en, unmapped;
  logic        w1c_fault, cnt_clr;
  logic [31:0] be_mask, thr_merged, rd_value;
  logic        unused_bits;

  assign reg_idx  = speriph_add_i[5:2];
  assign wr_en    = speriph_req_i & ~speriph_wen_i;
  assign rd_en    = speriph_req_i &  speriph_wen_i;
  assign unmapped = (reg_idx > IDX_THRESHOLD);
  assign be_mask  = {{8{speriph_be_i[3]}}, {8{speriph_be_i[2]}},
                     {8{speriph_be_i[1]}}, {8{speriph_be_i[0]}}};
  assign thr_merged  = (32'(thr_q) & ~be_mask) | (speriph_wdata_i & be_mask);
  assign unused_bits = ^{speriph_add_i[31:6], speriph_add_i[1:0], thr_merged};

  assign speriph_gnt_o = speriph_req_i;
  assign lockstep_en_o = ctrl_q[0];
  assign fault_irq_o   = ctrl_q[1] & (state_q == ST_FAULT);
  assign core_halt_o   = ctrl_q[2] & (state_q == ST_FAULT);

  always_comb begin
    rd_value = 32'h0;
    case (reg_idx)
      IDX_CTRL:       rd_value = {29'h0, ctrl_q};
      IDX_STATUS:     rd_value = {29'h0, (state_q == ST_FAULT), state_q};
      IDX_CNT:        rd_value = 32'(cnt_q);
      IDX_FIRST_PC:   rd_value = first_pc_q;
      IDX_FIRST_CORE: rd_value = 32'(first_core_q);
      IDX_THRESHOLD:  rd_value = 32'(thr_q);
      default:        rd_value = 32'h0;
    endcase
  end

  // Register writes are applied first; the mismatch event then sees the
  // post-write EN, cleared counter and effective state of this same cycle.
  always_comb begin
    ctrl_d       = ctrl_q;
    thr_d        = thr_q;
    first_pc_d   = first_pc_q;
    first_core_d = first_core_q;
    w1c_fault    = 1'b0;
    cnt_clr      = 1'b0;

    if (wr_en) begin
      case (reg_idx)
        IDX_CTRL:      if (speriph_be_i[0]) ctrl_d = speriph_wdata_i[2:0];
        IDX_STATUS:    w1c_fault = speriph_be_i[0] & speriph_wdata_i[2];
        IDX_CNT:       cnt_clr   = speriph_be_i[0];
        IDX_THRESHOLD: thr_d     = thr_merged[CNT_WIDTH-1:0];
        default:       ;
      endcase
    end

    cnt_base = cnt_clr ? '0 : cnt_q;

    state_eff = ctrl_d[0] ? ST_ARMED : ST_DISABLED;
    if (state_q == ST_FAULT) begin
      if (w1c_fault) begin
        cnt_base = '0;
      end else begin
        state_eff = ST_FAULT;
      end
    end

    thr_eff = (thr_d == '0) ? CNT_WIDTH'(1) : thr_d;
    cnt_inc = (cnt_base == '1) ? cnt_base : cnt_base + CNT_WIDTH'(1);
    cnt_d   = cnt_base;
    state_d = state_eff;

    if (mismatch_i && (state_eff != ST_DISABLED)) begin
      cnt_d = cnt_inc;
      // Captures stay frozen while in FAULT.
      if (state_eff == ST_ARMED) begin
        if (cnt_base == '0) begin
          first_pc_d   = mismatch_pc_i;
          first_core_d = mismatch_core_i;
        end
        if (cnt_inc >= thr_eff) state_d = ST_FAULT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_DISABLED;
      ctrl_q       <= 3'h0;
      thr_q        <= CNT_WIDTH'(DEFAULT_THRESHOLD);
      cnt_q        <= '0;
      first_pc_q   <= 32'h0;
      first_core_q <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      thr_q        <= thr_d;
      cnt_q        <= cnt_d;
      first_pc_q   <= first_pc_d;
      first_core_q <= first_core_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      speriph_r_valid_o <= 1'b0;
      speriph_r_rdata_o <= 32'h0;
      speriph_r_opc_o   <= 1'b0;
      speriph_r_id_o    <= '0;
    end else begin
      speriph_r_valid_o <= speriph_req_i;
      speriph_r_rdata_o <= rd_en ? rd_value : 32'h0;
      speriph_r_opc_o   <= speriph_req_i & unmapped;
      speriph_r_id_o    <= speriph_req_i ? speriph_id_i : '0;
    end
  end

endmodule
